clarvi_mem_arbiter: RTL and testbench
=====================================

// Module: clarvi_mem_arbiter
// PURPOSE
//  Shares one pipelined Avalon-MM memory port between the instruction-fetch master and the
//  data (load/store) master of the 16-bit-slice core. Sits below fetch/memory-access stages;
//  sources the instr_wait/main_wait and read-data-valid signals the decode stall logic consumes.
//  Tracks outstanding reads in order and routes each readdatavalid back to its owner.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width, all ports
//  DATA_WIDTH   16  data width; multiple of 8
//  MAX_PENDING  4   outstanding reads tracked (owner FIFO depth, power of 2, >=2)
// PORTS
//  clock            in   1    core clock
//  reset_n          in   1    asynchronous active-low reset
//  instr_address    in   AW   fetch address
//  instr_read       in   1    fetch read request (held until !instr_wait)
//  instr_wait       out  1    fetch waitrequest
//  instr_rdata      out  DW   fetch read data
//  instr_rvalid     out  1    fetch read data valid
//  main_address     in   AW   data address
//  main_read        in   1    data read request
//  main_write       in   1    data write request (never with main_read)
//  main_byteenable  in   DW/8 data byte enables
//  main_wdata       in   DW   data write data
//  main_wait        out  1    data waitrequest
//  main_rdata       out  DW   data read data
//  main_rvalid      out  1    data read data valid
//  mem_address/mem_read/mem_write/mem_byteenable/mem_wdata  out  downstream request
//  mem_waitrequest  in   1    downstream waitrequest
//  mem_rdata        in   DW   downstream read data
//  mem_rvalid       in   1    downstream readdatavalid (in request order)
//  err_orphan_rsp   out  1    sticky: mem_rvalid arrived with owner FIFO empty
// BEHAVIOUR
//  - Reset: all outputs 0 except instr_wait=main_wait=1 until first cycle after release; FSM=IDLE,
//    FIFO empty, priority pointer=DATA, err_orphan_rsp=0. Async assert, sync deassert externally.
//  - FSM: IDLE, HOLD_I, HOLD_D. IDLE: pick requester combinationally, drive mem_* same cycle;
//    if mem_waitrequest=1 go HOLD_x, else transfer completes, stay IDLE. HOLD_x: keep grant
//    (no switching while Avalon address must stay stable) until mem_waitrequest=0 -> IDLE.
//  - Default priority: data beats instr when both request in IDLE.
//  - Loser sees its *_wait=1; winner's *_wait = mem_waitrequest | fifo_block.
//  - fifo_block: read request when FIFO full and no pop this cycle -> mem_read held 0, requester
//    waits; a same-cycle pop frees the slot (push+pop when full allowed). Writes never block.
//  - Accepted read (mem_read & !mem_waitrequest) pushes owner bit (0=instr,1=data).
//  - mem_rvalid pops head; routes mem_rdata to owner's *_rdata, asserts that *_rvalid same
//    cycle (zero-latency combinational routing). Other *_rvalid=0; *_rdata is don't-care when !rvalid.
//  - mem_rvalid with FIFO empty: dropped, err_orphan_rsp set until reset.
//  - Requester dropping request while in HOLD_x is protocol error; behaviour undefined (assert in sim).
//  - Reset mid-operation: FIFO flushed; late responses for flushed reads hit orphan rule.
// CONFIGURATION
//  CLARVI_ARB_ROUND_ROBIN_EN: when defined, IDLE ties go to the requester not granted last
//  (pointer updates on each completed transfer). Undefined: fixed data-over-instr priority.
// STRUCTURE
//  Package clarvi_arb_pkg: arb_state_t {IDLE,HOLD_I,HOLD_D}, owner_t {OWNER_INSTR,OWNER_DATA}.
//  Sub-module clarvi_owner_fifo (1-bit wide, MAX_PENDING deep, full/empty, push+pop same cycle).
// TESTING
//  1 Both read in IDLE, mem_waitrequest=0 -> data granted; instr_wait=1; next cycle instr granted.
//  2 Data write addr 0x100, mem_waitrequest=1 for 3 cycles, instr_read raised -> grant held 4 cycles,
//    mem_address stable 0x100, instr gets grant only after.
//  3 Issue instr,data,instr reads, rvalid 3 cycles later each -> instr_rvalid,main_rvalid,instr_rvalid
//    in order with data 0xA1,0xB2,0xC3.
//  4 Fill 4 reads with no rvalid -> 5th read blocked (mem_read=0); rvalid same cycle -> accepted.
//  5 mem_rvalid with empty FIFO -> err_orphan_rsp=1, no *_rvalid; stays 1 until reset_n=0.
//  6 With CLARVI_ARB_ROUND_ROBIN_EN, continuous dual reads -> grants alternate D,I,D,I.

Source files
------------

// File: rtl/clarvi_arb_pkg.sv
// Shared types for the clarvi instruction/data memory arbiter.
package clarvi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/clarvi_owner_fifo.sv
// In-order owner tag queue for outstanding reads; 1 bit per entry.
// Push and pop may share a cycle, including while full.
module clarvi_owner_fifo
    import clarvi_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   push,
    input  owner_t push_owner,
    input  logic   pop,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DEPTH-1:0] slots_q, slots_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    assign head  = owner_t'(slots_q[rd_ptr_q]);
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            slots_d[wr_ptr_q] = push_owner;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slots_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slots_q  <= slots_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Shares one pipelined Avalon-MM port between fetch and load/store masters.
// Define CLARVI_ARB_ROUND_ROBIN_EN for round-robin ties instead of data-first.
module clarvi_mem_arbiter
    import clarvi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   instr_address,
    input  logic                    instr_read,
    output logic                    instr_wait,
    output logic [DATA_WIDTH-1:0]   instr_rdata,
    output logic                    instr_rvalid,
    input  logic [ADDR_WIDTH-1:0]   main_address,
    input  logic                    main_read,
    input  logic                    main_write,
    input  logic [DATA_WIDTH/8-1:0] main_byteenable,
    input  logic [DATA_WIDTH-1:0]   main_wdata,
    output logic                    main_wait,
    output logic [DATA_WIDTH-1:0]   main_rdata,
    output logic                    main_rvalid,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid,
    output logic                    err_orphan_rsp
);

    arb_state_t state_q, state_d;
    logic       rst_done_q;
    logic       err_q, err_d;
    logic       gnt_i, gnt_d, req_rd, blocked;
    logic       pop, push, issued;
    logic       fifo_full, fifo_empty;
    owner_t     head, push_owner;
    logic       instr_req, data_req;

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
    owner_t     prio_q, prio_d;
`endif

    assign instr_req = instr_read;
    assign data_req  = main_read | main_write;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_done_q) begin
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
                    gnt_d = data_req & (!instr_req | (prio_q == OWNER_DATA));
`else
                    gnt_d = data_req;
`endif
                    gnt_i = instr_req & !gnt_d;
                end
            end
            HOLD_I:  gnt_i = 1'b1;
            HOLD_D:  gnt_d = 1'b1;
            default: ;
        endcase
    end

    // A full queue stalls a new read unless a response frees a slot this cycle
    assign pop        = mem_rvalid & !fifo_empty;
    assign req_rd     = gnt_i | (gnt_d & main_read);
    assign blocked    = req_rd & fifo_full & !pop;
    assign mem_read   = req_rd & !blocked;
    assign mem_write  = gnt_d & main_write;
    assign issued     = mem_read | mem_write;
    assign push       = mem_read & !mem_waitrequest;
    assign push_owner = gnt_d ? OWNER_DATA : OWNER_INSTR;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_wdata      = '0;
        if (gnt_d) begin
            mem_address    = main_address;
            mem_byteenable = main_byteenable;
            mem_wdata      = main_wdata;
        end else if (gnt_i) begin
            mem_address    = instr_address;
            mem_byteenable = '1;
        end
    end

    assign instr_wait = !rst_done_q
                      | (instr_req & (!gnt_i | mem_waitrequest | blocked));
    assign main_wait  = !rst_done_q
                      | (data_req & (!gnt_d | mem_waitrequest | blocked));

    assign instr_rvalid = pop & (head == OWNER_INSTR);
    assign main_rvalid  = pop & (head == OWNER_DATA);
    assign instr_rdata  = instr_rvalid ? mem_rdata : '0;
    assign main_rdata   = main_rvalid ? mem_rdata : '0;

    assign err_orphan_rsp = err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q | (mem_rvalid & fifo_empty);
        case (state_q)
            IDLE: begin
                if (issued && mem_waitrequest) begin
                    state_d = gnt_d ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I, HOLD_D: begin
                if (!mem_waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
    always_comb begin
        prio_d = prio_q;
        if (issued && !mem_waitrequest) begin
            prio_d = gnt_d ? OWNER_INSTR : OWNER_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= OWNER_DATA;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == HOLD_I) begin
                assert (instr_read)
                    else $error("instr_read released during held grant");
            end
            if (state_q == HOLD_D) begin
                assert (main_read | main_write)
                    else $error("main request released during held grant");
            end
        end
    end

    clarvi_owner_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_owner_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_owner (push_owner),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed checks for clarvi_mem_arbiter; honours CLARVI_ARB_ROUND_ROBIN_EN.
module tb_clarvi_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_wait;
    logic [15:0] instr_rdata;
    logic        instr_rvalid;
    logic [31:0] main_address;
    logic        main_read;
    logic        main_write;
    logic [1:0]  main_byteenable;
    logic [15:0] main_wdata;
    logic        main_wait;
    logic [15:0] main_rdata;
    logic        main_rvalid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_wdata;
    logic        mem_waitrequest;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        err_orphan_rsp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    clarvi_mem_arbiter dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .instr_address   (instr_address),
        .instr_read      (instr_read),
        .instr_wait      (instr_wait),
        .instr_rdata     (instr_rdata),
        .instr_rvalid    (instr_rvalid),
        .main_address    (main_address),
        .main_read       (main_read),
        .main_write      (main_write),
        .main_byteenable (main_byteenable),
        .main_wdata      (main_wdata),
        .main_wait       (main_wait),
        .main_rdata      (main_rdata),
        .main_rvalid     (main_rvalid),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_wdata       (mem_wdata),
        .mem_waitrequest (mem_waitrequest),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .err_orphan_rsp  (err_orphan_rsp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        instr_read      = 1'b0;
        main_read       = 1'b0;
        main_write      = 1'b0;
        mem_waitrequest = 1'b0;
        mem_rvalid      = 1'b0;
        mem_rdata       = 16'h0;
    endtask

    logic [31:0] exp_rr [4];

    initial begin
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
        exp_rr = '{32'h30, 32'h20, 32'h30, 32'h20};
`else
        exp_rr = '{32'h30, 32'h30, 32'h30, 32'h30};
`endif
        reset_n         = 1'b0;
        instr_address   = 32'h0;
        main_address    = 32'h0;
        main_byteenable = 2'b11;
        main_wdata      = 16'h0;
        idle_inputs();
        instr_read      = 1'b1;

        // reset state, with a request pending
        smp();
        chk("rst_instr_wait", instr_wait, 1);
        chk("rst_main_wait", main_wait, 1);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_err", err_orphan_rsp, 0);
        chk("rst_instr_rvalid", instr_rvalid, 0);
        nxt();
        reset_n = 1'b1;
        idle_inputs();
        smp();
        chk("rel_instr_wait", instr_wait, 1);
        chk("rel_main_wait", main_wait, 1);
        nxt();
        smp();
        chk("run_instr_wait", instr_wait, 0);
        chk("run_main_wait", main_wait, 0);

        // 1: simultaneous reads, data wins
        nxt();
        instr_read    = 1'b1;
        instr_address = 32'h10;
        main_read     = 1'b1;
        main_address  = 32'h20;
        smp();
        chk("t1_addr_d", mem_address, 32'h20);
        chk("t1_read_d", mem_read, 1);
        chk("t1_main_wait", main_wait, 0);
        chk("t1_instr_wait", instr_wait, 1);
        nxt();
        main_read = 1'b0;
        smp();
        chk("t1_addr_i", mem_address, 32'h10);
        chk("t1_instr_wait2", instr_wait, 0);
        chk("t1_be_i", mem_byteenable, 2'b11);
        nxt();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h0011;
        smp();
        chk("t1_main_rvalid", main_rvalid, 1);
        chk("t1_main_rdata", main_rdata, 16'h0011);
        chk("t1_instr_rvalid0", instr_rvalid, 0);
        nxt();
        mem_rdata = 16'h0022;
        smp();
        chk("t1_instr_rvalid", instr_rvalid, 1);
        chk("t1_instr_rdata", instr_rdata, 16'h0022);

        // 2: stalled write keeps the grant for 4 cycles
        nxt();
        idle_inputs();
        main_write      = 1'b1;
        main_address    = 32'h100;
        main_wdata      = 16'hBEEF;
        main_byteenable = 2'b01;
        instr_read      = 1'b1;
        instr_address   = 32'h40;
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t2_write_held", mem_write, 1);
            chk("t2_addr_held", mem_address, 32'h100);
            chk("t2_main_wait", main_wait, 1);
            chk("t2_instr_wait", instr_wait, 1);
            chk("t2_no_read", mem_read, 0);
            nxt();
        end
        mem_waitrequest = 1'b0;
        smp();
        chk("t2_write_last", mem_write, 1);
        chk("t2_addr_last", mem_address, 32'h100);
        chk("t2_wdata", mem_wdata, 16'hBEEF);
        chk("t2_be", mem_byteenable, 2'b01);
        chk("t2_main_done", main_wait, 0);
        chk("t2_instr_still", instr_wait, 1);
        nxt();
        main_write = 1'b0;
        smp();
        chk("t2_instr_addr", mem_address, 32'h40);
        chk("t2_instr_read", mem_read, 1);
        chk("t2_instr_go", instr_wait, 0);
        nxt();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h0055;
        smp();
        chk("t2_drain", instr_rvalid, 1);

        // 3: responses routed in request order
        nxt();
        idle_inputs();
        instr_read    = 1'b1;
        instr_address = 32'h50;
        nxt();
        instr_read   = 1'b0;
        main_read    = 1'b1;
        main_address = 32'h60;
        nxt();
        main_read  = 1'b0;
        instr_read = 1'b1;
        nxt();
        instr_read = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h00A1;
        smp();
        chk("t3_r1_i", instr_rvalid, 1);
        chk("t3_r1_m", main_rvalid, 0);
        chk("t3_r1_data", instr_rdata, 16'h00A1);
        nxt();
        mem_rdata = 16'h00B2;
        smp();
        chk("t3_r2_i", instr_rvalid, 0);
        chk("t3_r2_m", main_rvalid, 1);
        chk("t3_r2_data", main_rdata, 16'h00B2);
        nxt();
        mem_rdata = 16'h00C3;
        smp();
        chk("t3_r3_i", instr_rvalid, 1);
        chk("t3_r3_m", main_rvalid, 0);
        chk("t3_r3_data", instr_rdata, 16'h00C3);

        // 4: full queue blocks, same-cycle response unblocks
        nxt();
        idle_inputs();
        instr_read    = 1'b1;
        instr_address = 32'h80;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t4_fill", mem_read, 1);
            nxt();
        end
        smp();
        chk("t4_blocked_read", mem_read, 0);
        chk("t4_blocked_wait", instr_wait, 1);
        nxt();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h0077;
        smp();
        chk("t4_unblock_read", mem_read, 1);
        chk("t4_unblock_wait", instr_wait, 0);
        chk("t4_unblock_rvalid", instr_rvalid, 1);
        nxt();
        instr_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t4_drain", instr_rvalid, 1);
            nxt();
        end

        // 5: orphan response is dropped and sticky
        smp();
        chk("t5_no_irv", instr_rvalid, 0);
        chk("t5_no_mrv", main_rvalid, 0);
        nxt();
        mem_rvalid = 1'b0;
        smp();
        chk("t5_err_set", err_orphan_rsp, 1);
        nxt();
        smp();
        chk("t5_err_sticky", err_orphan_rsp, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_err_clear", err_orphan_rsp, 0);
        nxt();
        reset_n = 1'b1;
        nxt();

        // 6: continuous dual reads
        instr_read    = 1'b1;
        instr_address = 32'h20;
        main_read     = 1'b1;
        main_address  = 32'h30;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t6_grant_addr", mem_address, exp_rr[i]);
            chk("t6_read", mem_read, 1);
            nxt();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
